// File: rtl/cpu_sequencer_pkg.sv
// Shared types for the accumulator CPU: opcode and sequencer state enums,
// plus the ALU-operand opcode test used by both the sequencer and the decoder.
package typedefs;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_t;

  // Opcodes that read a memory operand and feed it to the ALU.
  function automatic logic is_aluop(input opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/cpu_sequencer_seq_decode.sv
// Combinational strobe decoder: maps the current phase, opcode and ALU zero
// flag onto the datapath control strobes.
module seq_decode
  import typedefs::*;
(
  input  state_t  phase,
  input  opcode_t opcode,
  input  logic    zero,
  output logic    mem_rd,
  output logic    mem_wr,
  output logic    load_ir,
  output logic    load_ac,
  output logic    load_pc,
  output logic    inc_pc,
  output logic    sel,
  output logic    data_e
);

  logic aluop;

  assign aluop = is_aluop(opcode);

  always_comb begin
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    load_ir = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    inc_pc  = 1'b0;
    sel     = 1'b0;
    data_e  = 1'b0;
    case (phase)
      INST_ADDR: begin
        sel = 1'b1;
      end
      INST_FETCH: begin
        sel    = 1'b1;
        mem_rd = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel     = 1'b1;
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = 1'b1;
      end
      OP_FETCH: begin
        mem_rd = aluop;
      end
      ALU_OP: begin
        mem_rd  = aluop;
        inc_pc  = (opcode == SKZ) && zero;
        load_pc = (opcode == JMP);
      end
      // JMP raises inc_pc alongside load_pc; the load takes priority in the PC.
      STORE: begin
        mem_rd  = aluop;
        load_ac = aluop;
        inc_pc  = (opcode == JMP);
        load_pc = (opcode == JMP);
        data_e  = (opcode == STO);
        mem_wr  = (opcode == STO);
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Eight-phase fetch/execute sequencer with memory wait states, halt/resume,
// single-step mode and a retired-instruction counter.
module cpu_sequencer
  import typedefs::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  opcode_t          opcode,
  input  logic             zero,
  input  logic             mem_rdy,
  input  logic             go,
  input  logic             step_en,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             load_ir,
  output logic             load_ac,
  output logic             load_pc,
  output logic             inc_pc,
  output logic             sel,
  output logic             data_e,
  output logic             halted,
  output state_t           phase,
  output logic [CNT_W-1:0] instr_cnt
);

  // Fetch states stall on mem_rdy; STORE retires the instruction and counts it.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      phase     <= INST_ADDR;
      instr_cnt <= '0;
    end else begin
      case (phase)
        INST_ADDR:  phase <= INST_FETCH;
        INST_FETCH: if (mem_rdy) phase <= INST_LOAD;
        INST_LOAD:  phase <= IDLE;
        IDLE:       phase <= OP_ADDR;
        OP_ADDR:    phase <= (opcode == HLT) ? HALTED : OP_FETCH;
        OP_FETCH:   if (mem_rdy || !is_aluop(opcode)) phase <= ALU_OP;
        ALU_OP:     phase <= STORE;
        STORE: begin
          phase     <= step_en ? HALTED : INST_ADDR;
          instr_cnt <= instr_cnt + 1'b1;
        end
        HALTED:     if (go) phase <= INST_ADDR;
        default:    phase <= INST_ADDR;
      endcase
    end
  end

  assign halted = (phase == HALTED);

  seq_decode u_decode (
    .phase   (phase),
    .opcode  (opcode),
    .zero    (zero),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_wr),
    .load_ir (load_ir),
    .load_ac (load_ac),
    .load_pc (load_pc),
    .inc_pc  (inc_pc),
    .sel     (sel),
    .data_e  (data_e)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: phase walk, strobe decode, stalls,
// halt/resume, single-step, async reset and counter wrap.
module tb_cpu_sequencer;
  import typedefs::*;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_;
  opcode_t          opcode;
  logic             zero;
  logic             mem_rdy;
  logic             go;
  logic             step_en;
  logic             mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, sel, data_e;
  logic             halted;
  state_t           phase;
  logic [CNT_W-1:0] instr_cnt;
  logic [7:0]       strobes;

  int assertCount = 0;
  int failCount   = 0;
  int expCnt      = 0;
  int cycles;

  // Strobe byte: mem_rd mem_wr load_ir load_ac load_pc inc_pc sel data_e
  assign strobes = {mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, sel, data_e};

  cpu_sequencer #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .opcode    (opcode),
    .zero      (zero),
    .mem_rdy   (mem_rdy),
    .go        (go),
    .step_en   (step_en),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .load_ir   (load_ir),
    .load_ac   (load_ac),
    .load_pc   (load_pc),
    .inc_pc    (inc_pc),
    .sel       (sel),
    .data_e    (data_e),
    .halted    (halted),
    .phase     (phase),
    .instr_cnt (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // One unstalled instruction from INST_ADDR, checking phase and strobes each clock.
  task automatic runInstr(input string tag, input opcode_t op, input logic z,
                          input logic [7:0] sFetch, input logic [7:0] sAlu, input logic [7:0] sStore);
    state_t     expPhase [8];
    logic [7:0] expStrobe[8];
    expPhase  = '{INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE};
    expStrobe = '{8'h02, 8'h82, 8'hA2, 8'hA2, 8'h04, sFetch, sAlu, sStore};
    opcode  = op;
    zero    = z;
    mem_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("%s phase%0d", tag, i), 32'(phase), 32'(expPhase[i]));
      checkOutput($sformatf("%s strobes%0d", tag, i), 32'(strobes), 32'(expStrobe[i]));
      applyStimulus();
    end
    expCnt = (expCnt + 1) % (1 << CNT_W);
    checkOutput($sformatf("%s end phase", tag), 32'(phase), 32'(INST_ADDR));
    checkOutput($sformatf("%s instr_cnt", tag), 32'(instr_cnt), 32'(expCnt));
  endtask

  initial begin
    rst_    = 1'b0;
    opcode  = LDA;
    zero    = 1'b0;
    mem_rdy = 1'b1;
    go      = 1'b0;
    step_en = 1'b0;
    repeat (2) applyStimulus();
    checkOutput("reset phase", 32'(phase), 32'(INST_ADDR));
    checkOutput("reset instr_cnt", 32'(instr_cnt), 32'd0);
    checkOutput("reset halted", 32'(halted), 32'd0);
    checkOutput("reset strobes", 32'(strobes), 32'h02);
    rst_ = 1'b1;

    runInstr("LDA", LDA, 1'b0, 8'h80, 8'h80, 8'h90);
    runInstr("SKZ z1", SKZ, 1'b1, 8'h00, 8'h04, 8'h00);
    runInstr("SKZ z0", SKZ, 1'b0, 8'h00, 8'h00, 8'h00);
    runInstr("STO", STO, 1'b0, 8'h00, 8'h00, 8'h41);
    runInstr("JMP", JMP, 1'b0, 8'h00, 8'h08, 8'h0C);

    // Three wait states in INST_FETCH
    opcode = ADD;
    applyStimulus();
    cycles = 1;
    mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("stall phase%0d", i), 32'(phase), 32'(INST_FETCH));
      checkOutput($sformatf("stall strobes%0d", i), 32'(strobes), 32'h82);
      applyStimulus();
      cycles++;
    end
    mem_rdy = 1'b1;
    while (phase != INST_ADDR && cycles < 30) begin
      applyStimulus();
      cycles++;
    end
    expCnt++;
    checkOutput("stall clocks", 32'(cycles), 32'd11);
    checkOutput("stall instr_cnt", 32'(instr_cnt), 32'(expCnt));

    // HLT and go resume
    opcode = HLT;
    repeat (4) applyStimulus();
    checkOutput("hlt op_addr", 32'(phase), 32'(OP_ADDR));
    checkOutput("hlt inc_pc", 32'(strobes), 32'h04);
    applyStimulus();
    checkOutput("hlt phase", 32'(phase), 32'(HALTED));
    checkOutput("hlt halted", 32'(halted), 32'd1);
    checkOutput("hlt strobes", 32'(strobes), 32'h00);
    checkOutput("hlt instr_cnt", 32'(instr_cnt), 32'(expCnt));
    repeat (2) applyStimulus();
    checkOutput("hlt hold", 32'(phase), 32'(HALTED));
    go = 1'b1;
    applyStimulus();
    go = 1'b0;
    checkOutput("go resume", 32'(phase), 32'(INST_ADDR));
    checkOutput("go halted", 32'(halted), 32'd0);

    // Single-step ADD, with go also high in STORE
    opcode  = ADD;
    step_en = 1'b1;
    repeat (7) applyStimulus();
    checkOutput("step store", 32'(phase), 32'(STORE));
    go = 1'b1;
    applyStimulus();
    go = 1'b0;
    expCnt++;
    checkOutput("step halted", 32'(phase), 32'(HALTED));
    checkOutput("step instr_cnt", 32'(instr_cnt), 32'(expCnt));
    applyStimulus();
    checkOutput("step hold", 32'(phase), 32'(HALTED));
    go = 1'b1;
    applyStimulus();
    go = 1'b0;
    step_en = 1'b0;
    checkOutput("step resume", 32'(phase), 32'(INST_ADDR));

    // mem_rdy ignored in OP_FETCH for a non-ALU opcode
    opcode = STO;
    repeat (5) applyStimulus();
    checkOutput("sto op_fetch", 32'(phase), 32'(OP_FETCH));
    mem_rdy = 1'b0;
    applyStimulus();
    checkOutput("sto no stall", 32'(phase), 32'(ALU_OP));
    mem_rdy = 1'b1;
    repeat (2) applyStimulus();
    expCnt++;
    checkOutput("sto instr_cnt", 32'(instr_cnt), 32'(expCnt));

    // Asynchronous reset in the middle of an OP_FETCH stall
    opcode = ADD;
    repeat (5) applyStimulus();
    mem_rdy = 1'b0;
    repeat (2) applyStimulus();
    checkOutput("opf stall phase", 32'(phase), 32'(OP_FETCH));
    checkOutput("opf stall strobes", 32'(strobes), 32'h80);
    #2;
    rst_ = 1'b0;
    #1;
    checkOutput("async rst phase", 32'(phase), 32'(INST_ADDR));
    checkOutput("async rst instr_cnt", 32'(instr_cnt), 32'd0);
    checkOutput("async rst strobes", 32'(strobes), 32'h02);
    applyStimulus();
    rst_    = 1'b1;
    mem_rdy = 1'b1;
    expCnt  = 0;

    // 2^CNT_W instructions wrap the counter to zero
    for (int n = 0; n < (1 << CNT_W); n++) begin
      repeat (8) applyStimulus();
      if (n == (1 << CNT_W) - 2)
        checkOutput("wrap max", 32'(instr_cnt), 32'((1 << CNT_W) - 1));
    end
    checkOutput("wrap zero", 32'(instr_cnt), 32'd0);
    checkOutput("wrap phase", 32'(phase), 32'(INST_ADDR));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
